// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU constants and the IEEE-754 single-precision struct
package fpu_pkg;

  localparam int FLT_W    = 32;
  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;
  localparam int EXP_BIAS = 127;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } float32_t;

endpackage

// File: rtl/itof_pipe_if.sv
// rtl/itof_pipe_if.sv - operand/result handshake bundle for itof_pipe
interface itof_pipe_if #(
  parameter int IN_W = 32
);
  import fpu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_unsigned;
  logic             out_valid;
  logic             out_ready;
  logic [FLT_W-1:0] out_data;

  modport master (
    output in_valid, in_data, in_unsigned, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_unsigned, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/itof_lzc.sv
// rtl/itof_lzc.sv - combinational leading-one detector: pos = index of the top set bit of v
module itof_lzc #(
  parameter  int IN_W = 32,
  localparam int PW   = $clog2(IN_W)
) (
  input  logic [IN_W-1:0] v,
  output logic [PW-1:0]   pos,
  output logic            zero
);

  // Later (higher) indices overwrite earlier ones, so the last hit is the MSB.
  always_comb begin
    pos = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (v[i]) begin
        pos = PW'(i);
      end
    end
  end

  assign zero = ~|v;

endmodule

// File: rtl/itof_pipe.sv
// rtl/itof_pipe.sv - 3-stage integer to IEEE single converter; define ITOF_RNE_EN for round-to-nearest-even, else truncation
module itof_pipe
  import fpu_pkg::*;
#(
  parameter int IN_W           = 32,
  parameter int DEFAULT_SIGNED = 1
) (
  input logic        clk,
  input logic        rst,
  itof_pipe_if.slave bus
);

  localparam int PW    = $clog2(IN_W);
  localparam int FW    = IN_W - 1;
  localparam int XW    = (FW > MANT_W) ? FW : MANT_W;
  localparam int XPW   = XW + 3;
  localparam int PADW  = XW - FW + 3;
  localparam int unused_default_signed = DEFAULT_SIGNED;

  logic adv;

  logic             s1_valid;
  logic             s1_sign;
  logic [IN_W-1:0]  s1_mag;

  logic             s2_valid;
  logic             s2_sign;
  logic             s2_zero;
  logic [PW-1:0]    s2_pos;
  logic [FW-1:0]    s2_frac;

  logic             s1_sign_c;
  logic [IN_W-1:0]  s1_mag_c;
  logic [PW-1:0]    lzc_pos;
  logic             lzc_zero;
  logic [PW-1:0]    shamt;
  logic [IN_W-1:0]  norm_c;
  logic             unused_lead;

  logic [XPW-1:0]    fx;
  logic [MANT_W-1:0] mant_t;
  logic [MANT_W-1:0] mant_r;
  logic [EXP_W-1:0]  exp_c;
  float32_t          res_c;

  // Single global advance: every stage moves or every stage holds.
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  assign s1_sign_c = !bus.in_unsigned && bus.in_data[IN_W-1];
  assign s1_mag_c  = s1_sign_c ? (~bus.in_data + IN_W'(1)) : bus.in_data;

  itof_lzc #(.IN_W(IN_W)) u_lzc (
    .v    (s1_mag),
    .pos  (lzc_pos),
    .zero (lzc_zero)
  );

  assign shamt       = PW'(IN_W - 1) - lzc_pos;
  assign norm_c      = s1_mag << shamt;
  assign unused_lead = norm_c[IN_W-1];

  // Fraction left-aligned with three spare zero bits so guard/round/sticky slices always exist.
  assign fx     = XPW'(s2_frac) << PADW;
  assign mant_t = fx[XPW-1 -: MANT_W];

`ifdef ITOF_RNE_EN
  logic guard_b;
  logic round_b;
  logic sticky_b;
  logic round_up;
  logic carry;

  assign guard_b  = fx[XW-MANT_W+2];
  assign round_b  = fx[XW-MANT_W+1];
  assign sticky_b = |fx[XW-MANT_W:0];
  assign round_up = guard_b && (round_b || sticky_b || mant_t[0]);
  assign {carry, mant_r} = {1'b0, mant_t} + {{MANT_W{1'b0}}, round_up};
  assign exp_c = EXP_W'(EXP_BIAS) + EXP_W'(s2_pos) + {{(EXP_W-1){1'b0}}, carry};
`else
  logic unused_tail;

  assign unused_tail = ^fx[XW-MANT_W+2:0];
  assign mant_r      = mant_t;
  assign exp_c       = EXP_W'(EXP_BIAS) + EXP_W'(s2_pos);
`endif

  always_comb begin
    res_c = '0;
    if (!s2_zero) begin
      res_c.sign = s2_sign;
      res_c.exp  = exp_c;
      res_c.mant = mant_r;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_sign       <= 1'b0;
      s1_mag        <= '0;
      s2_valid      <= 1'b0;
      s2_sign       <= 1'b0;
      s2_zero       <= 1'b0;
      s2_pos        <= '0;
      s2_frac       <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else if (adv) begin
      s1_valid      <= bus.in_valid;
      s1_sign       <= s1_sign_c;
      s1_mag        <= s1_mag_c;
      s2_valid      <= s1_valid;
      s2_sign       <= s1_sign;
      s2_zero       <= lzc_zero;
      s2_pos        <= lzc_pos;
      s2_frac       <= norm_c[IN_W-2:0];
      bus.out_valid <= s2_valid;
      if (s2_valid) begin
        bus.out_data <= res_c;
      end
    end
  end

endmodule

// File: tb/tb_itof_pipe.sv
// tb/tb_itof_pipe.sv - scoreboard bench for itof_pipe against a real-arithmetic reference model
module tb_itof_pipe;

  localparam int W = 32;
`ifdef ITOF_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  typedef struct {
    logic [31:0] exp;
    int          acc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  itof_pipe_if #(.IN_W(W)) bus  ();
  itof_pipe_if #(.IN_W(8)) bus8 ();

  itof_pipe #(.IN_W(W), .DEFAULT_SIGNED(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  itof_pipe #(.IN_W(8), .DEFAULT_SIGNED(0)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          errors = 0;
  int          checks = 0;
  exp_t        sbq[$];
  logic [31:0] drv_exp = '0;
  bit          drv_lat = 1'b0;
  bit          bp_mode = 1'b0;
  bit          held = 1'b0;
  logic [31:0] held_data = '0;
  int          first_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: value-level conversion via exact real arithmetic (exact for operands below 2^53).
  function automatic logic [31:0] ref_itof(input longint unsigned v, input bit uns, input int w);
    longint unsigned mask;
    longint unsigned mag;
    longint          mi;
    bit              sign;
    real             x;
    real             f;
    real             m;
    int              e;
    mask = (64'd1 << w) - 64'd1;
    v    = v & mask;
    sign = !uns && (((v >> (w - 1)) & 64'd1) != 0);
    mag  = sign ? (((mask - v) + 64'd1) & mask) : v;
    if (mag == 0) return 32'h0;
    x = real'(mag);
    e = 0;
    while (x >= 2.0) begin
      x = x / 2.0;
      e++;
    end
    f  = (x - 1.0) * 8388608.0;
    m  = $floor(f);
    mi = longint'(m);
    if (RNE && (((f - m) > 0.5) || (((f - m) == 0.5) && mi[0]))) mi++;
    if (mi == 64'd8388608) begin
      mi = 0;
      e++;
    end
    return {sign, 8'(127 + e), mi[22:0]};
  endfunction

  // Stimulus capture: every accepted operand pushes its expected result.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
    end else if (bus.in_valid && bus.in_ready) begin
      sbq.push_back('{exp: drv_exp, acc: cyc + 1, lat: drv_lat});
    end
  end

  // Output monitor: stability under stall, ordering, latency, in_ready rule.
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      chk("in_ready_rule", {31'b0, bus.in_ready}, {31'b0, (!bus.out_valid || bus.out_ready)});
      if (held) begin
        chk("stall_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("stall_data", bus.out_data, held_data);
      end
      if (bus.out_valid) begin
        if (!held) first_seen = cyc;
        if (bus.out_ready) begin
          held = 1'b0;
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got 0x%08h, required no output (cycle %0d)", bus.out_data, cyc);
          end else begin
            exp_t ent;
            ent = sbq.pop_front();
            chk("out_data", bus.out_data, ent.exp);
            if (ent.lat) chk("latency", 32'(first_seen - ent.acc), 32'd2);
          end
        end else begin
          held      = 1'b1;
          held_data = bus.out_data;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = bp_mode ? ($urandom_range(0, 1) != 0) : 1'b1;
    end
  end

  // Callers sit just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] d, input bit u, input logic [31:0] e);
    int n;
    n = 0;
    bus.in_data     = d;
    bus.in_unsigned = u;
    bus.in_valid    = 1'b1;
    drv_exp         = e;
    drv_lat         = !bp_mode;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required acceptance", n);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d results outstanding, required 0", sbq.size());
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send8(input logic [7:0] d, input bit u, input logic [31:0] e, input string name);
    int n;
    n = 0;
    bus8.in_data     = d;
    bus8.in_unsigned = u;
    bus8.in_valid    = 1'b1;
    chk("w8_in_ready", {31'b0, bus8.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    while (!bus8.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("w8_latency", 32'(n), 32'd3);
    chk(name, bus8.out_data, e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 7))
      0:       v = 32'h8000_0000 >> $urandom_range(0, 31);
      1:       v = (32'h0100_0000 << $urandom_range(0, 7)) | (v & 32'h3FF);
      default: v = v >> $urandom_range(0, 31);
    endcase
    if ($urandom_range(0, 1) != 0) v = -v;
    return v;
  endfunction

  initial begin
    logic [31:0] d;
    bit          u;

    rst              = 1'b1;
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.in_unsigned  = 1'b0;
    bus8.in_valid    = 1'b0;
    bus8.in_data     = '0;
    bus8.in_unsigned = 1'b0;
    bus8.out_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("reset_out_data", bus.out_data, 32'h0);
    chk("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);

    send(32'h0000_0001, 1'b0, 32'h3F80_0000);
    send(32'hFFFF_FFFF, 1'b0, 32'hBF80_0000);
    send(32'h0000_0000, 1'b0, 32'h0000_0000);
    send(32'h0000_0000, 1'b1, 32'h0000_0000);
    send(32'h8000_0000, 1'b0, 32'hCF00_0000);
    send(32'hFFFF_FFFF, 1'b1, RNE ? 32'h4F80_0000 : 32'h4F7F_FFFF);
    send(32'h8000_0000, 1'b1, 32'h4F00_0000);
    send(32'h0100_0001, 1'b0, 32'h4B80_0000);
    send(32'h0100_0003, 1'b0, RNE ? 32'h4B80_0002 : 32'h4B80_0001);
    send(32'h7FFF_FFFF, 1'b0, RNE ? 32'h4F00_0000 : 32'h4EFF_FFFF);
    send(32'h7FFF_FFFF, 1'b1, RNE ? 32'h4F00_0000 : 32'h4EFF_FFFF);
    drain();

    for (int i = 0; i < 60; i++) begin
      d = rand_operand();
      u = ($urandom_range(0, 1) != 0);
      send(d, u, ref_itof(64'(d), u, W));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    drain();

    bp_mode = 1'b1;
    for (int i = 0; i < 24; i++) begin
      d = rand_operand();
      u = ($urandom_range(0, 1) != 0);
      send(d, u, ref_itof(64'(d), u, W));
    end
    drain();
    bp_mode = 1'b0;
    idle(2);

    send(32'h0000_0005, 1'b0, 32'h40A0_0000);
    send(32'hFFFF_FFF9, 1'b0, 32'hC0E0_0000);
    send(32'h0000_0300, 1'b1, 32'h4440_0000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midreset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("midreset_out_data", bus.out_data, 32'h0);
    chk("midreset_in_ready", {31'b0, bus.in_ready}, 32'd1);
    send(32'h0000_0003, 1'b0, 32'h4040_0000);
    drain();
    idle(4);

    send8(8'h80, 1'b0, 32'hC300_0000, "w8_s_80");
    send8(8'hFF, 1'b1, 32'h437F_0000, "w8_u_ff");
    send8(8'h7F, 1'b0, 32'h42FE_0000, "w8_s_7f");
    send8(8'hFF, 1'b0, 32'hBF80_0000, "w8_s_ff");
    send8(8'h80, 1'b1, 32'h4300_0000, "w8_u_80");
    send8(8'h00, 1'b0, 32'h0000_0000, "w8_zero");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion by %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/itof_pipe.md
Name: itof_pipe

Overview:
Pipelined, parametrised integer-to-single-precision converter for the FPU execute path. It is the successor to the combinational itof and adds the following:
- configurable input width;
- per-operation signed/unsigned mode;
- a 3-stage pipeline with valid/ready flow control;
- optional IEEE round-to-nearest-even.

It sits between the FPU issue stage and the writeback arbiter.

Parameters:
IN_W, 32, integer operand width; legal range 2..64.
DEFAULT_SIGNED, 1, value of the signedness mode held while in_valid=0. Documentation only; has no functional effect on accepted operations.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand present
in_ready  out  1  block can accept an operand this cycle
in_data  in  IN_W  integer operand
in_unsigned  in  1  1 = treat in_data as unsigned; 0 = two's complement
out_valid  out  1  result present
out_ready  in  1  consumer accepts result
out_data  out  32  IEEE-754 single result {sign, exp[7:0], mant[22:0]}

Behaviour:
- Reset, sampled at a clock edge with rst=1: all stage valid bits clear, out_valid=0, out_data=0. in_ready=1 from the first cycle after reset. In-flight operations are discarded, with no partial output.
- Handshake: transfer occurs when valid && ready on the same edge.
- Global advance: adv = !out_valid || out_ready, and in_ready = adv. All stages shift together when adv=1 and all hold when adv=0.
- out_data is stable while out_valid && !out_ready.
- Bubbles: pipeline stages with valid=0 still shift, so bubbles collapse only at the output.
- Latency: exactly 3 cycles from acceptance to out_valid when there is no backpressure. Throughput is 1 per cycle.
- S1 (magnitude):
  - sign = !in_unsigned && in_data[IN_W-1].
  - mag = sign ? -in_data : in_data, as an IN_W-bit unsigned value. The most negative signed input, 2^(IN_W-1), fits in mag.
- S2 (normalise):
  - p = index of the most significant 1 in mag, taken from the leading-zero counter.
  - zero flag = (mag == 0).
  - norm = mag << (IN_W-1-p), so the leading 1 sits at norm[IN_W-1].
- S3 (pack):
  - Exponent = 127 + p. This cannot overflow for IN_W ≤ 64.
  - Mantissa = the 23 bits below the leading 1, zero-padded on the right when IN_W-1 < 23. Bits below these are either dropped or rounded (see Optional Feature).
  - If rounding carries out of the mantissa: mantissa = 0 and exponent + 1.
  - Zero input gives +0 (0x00000000) regardless of mode; there is never a -0.
- No exceptions and no flags.
- Unsigned mode with in_data[IN_W-1]=1 is a legal large positive value.

Optional Feature:
Macro ITOF_RNE_EN.
- Defined: IEEE round-to-nearest, ties-to-even, using guard, round and sticky bits from the truncated part of norm. Includes the mantissa-carry exponent bump.
- Undefined: truncation toward zero; the discarded bits are ignored, and no rounding logic or S3 adder is built.
- Latency and handshake are identical in both builds.

Decomposition:
- Package fpu_pkg holds:
  - constants FLT_W=32, EXP_W=8, MANT_W=23, EXP_BIAS=127;
  - typedef float32_t as a packed struct {sign, exp, mant}.
- One sub-module, itof_lzc: parametrised combinational leading-one detector.
  - Interface: input [IN_W-1:0] v; outputs pos [$clog2(IN_W)-1:0] and zero.
  - Instantiated in S2.
- All pipeline registers and handshake logic live in itof_pipe.

Test Plan:
- IN_W=32, signed:
  - 1 → 0x3F800000.
  - -1 → 0xBF800000.
  - 0 → 0x00000000.
  - 0x80000000 → 0xCF000000.
  - Each result appears exactly 3 cycles after acceptance.
- IN_W=32, unsigned:
  - 0xFFFFFFFF → 0x4F800000 with ITOF_RNE_EN, 0x4F7FFFFF without.
  - 0x80000000 → 0x4F000000.
- Rounding boundaries:
  - 0x01000001 → 0x4B800000 in both builds.
  - 0x01000003 → 0x4B800002 (RNE) or 0x4B800001 (truncation).
  - Signed 0x7FFFFFFF → 0x4F000000 (RNE) or 0x4EFFFFFF (truncation).
- Backpressure:
  - Stream 8 back-to-back operands with out_ready toggling pseudo-randomly.
  - Required: in order, no loss or duplication, out_data stable while stalled, and in_ready=0 whenever out_valid && !out_ready.
- Reset mid-stream: assert rst for 1 cycle with 3 operations in flight → out_valid=0 and out_data=0 the next cycle, no stale result ever emitted, and a new operand accepted immediately afterwards.
- IN_W=8 build:
  - Signed 0x80 → 0xC3000000.
  - Unsigned 0xFF → 0x437F0000.
  - Confirms mantissa zero-padding.
